// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Instruction-register, memory-handshake and datapath-control
//                bundle between the multicycle controller and its datapath.
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;

    logic       pcwrite;
    logic       irwrite;
    logic       iord;
    logic       memreq;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       branch;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic       hilotoreg;
    logic       hiorlo;
    logic       hiwrite;
    logic       lowrite;
    logic       mdu_busy;
    logic       bus_timeout;
    logic [3:0] state;

    // Controller side: consumes instruction fields and memory handshake.
    modport master (
        input  op, funct, mem_ready,
        output pcwrite, irwrite, iord, memreq, memwrite, regwrite, regdst,
               memtoreg, alusrca, branch, pcsrc, alusrcb, aluop, hilotoreg,
               hiorlo, hiwrite, lowrite, mdu_busy, bus_timeout, state
    );

    // Datapath side: supplies instruction fields, obeys the controls.
    modport slave (
        output op, funct, mem_ready,
        input  pcwrite, irwrite, iord, memreq, memwrite, regwrite, regdst,
               memtoreg, alusrca, branch, pcsrc, alusrcb, aluop, hilotoreg,
               hiorlo, hiwrite, lowrite, mdu_busy, bus_timeout, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore-style main control FSM for a multicycle MIPS-like core
//                with memory wait timeout and an optional multiply/divide
//                sequencing state.
//  Options     : define MULTICYCLE_CTRL_MDU_EN to build the MDU state/counter.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MDU_CYCLES     = 32,   // 1..63
    parameter int MEM_WAIT_LIMIT = 15    // 1..255
) (
    input  wire               clk,
    input  wire               resetn,
    multicycle_ctrl_if.master bus
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes handled outside RTEXE
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MTHI   = 6'h11;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MTLO   = 6'h13;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_LUI   = 4'd7;
    localparam logic [3:0] ALU_RTYPE = 4'd8;

    // Last wait cycle index before the access is declared dead
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_HILOWB = 4'd12,
        S_MDU    = 4'd13
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_timeout_q, bus_timeout_d;

    logic       mem_phase;
    logic       mem_wait;
    logic       timeout_hit;

`ifdef MULTICYCLE_CTRL_MDU_EN
    localparam logic [5:0] MDU_LOAD = 6'(MDU_CYCLES - 1);
    logic [5:0] mdu_cnt_q, mdu_cnt_d;
`endif

    // Instruction class lookup done once in DECODE; funct only matters for R-type.
    function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct);
        state_t nxt;
        nxt = S_FETCH;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: nxt = S_HILOWB;
`ifdef MULTICYCLE_CTRL_MDU_EN
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: nxt = S_MDU;
`else
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: nxt = S_FETCH;
`endif
                    default:                            nxt = S_RTEXE;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:                        nxt = S_MEMADR;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:           nxt = S_IMMEX;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_BGTZ:                                    nxt = S_BRANCH;
            OP_J, OP_JAL:                               nxt = S_JUMP;
            default:                                    nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    // A memory wait cycle is any cycle a request is outstanding without ready.
    assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_wait    = mem_phase && !bus.mem_ready;
    assign timeout_hit = mem_wait && (wait_cnt_q == WAIT_LAST);

    // Consecutive-wait counter and sticky timeout flag.
    always_comb begin
        wait_cnt_d    = 8'd0;
        bus_timeout_d = bus_timeout_q | timeout_hit;
        if (mem_wait && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Next-state logic; the instruction fields are captured in DECODE so later
    // states decode from registered copies.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
`ifdef MULTICYCLE_CTRL_MDU_EN
        mdu_cnt_d = mdu_cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d    = bus.op;
                funct_d = bus.funct;
                state_d = dispatch(bus.op, bus.funct);
`ifdef MULTICYCLE_CTRL_MDU_EN
                mdu_cnt_d = MDU_LOAD;
`endif
            end
            S_MEMADR: state_d = op_q[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready || timeout_hit) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEXE:  state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
`ifdef MULTICYCLE_CTRL_MDU_EN
            S_MDU: begin
                if (mdu_cnt_q == 6'd0) begin
                    state_d = S_FETCH;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - 6'd1;
                end
            end
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // State, captured instruction fields, wait counter and timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_FETCH;
            op_q          <= 6'd0;
            funct_q       <= 6'd0;
            wait_cnt_q    <= 8'd0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            funct_q       <= funct_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

`ifdef MULTICYCLE_CTRL_MDU_EN
    // MDU occupancy down-counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdu_cnt_q <= 6'd0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end
`endif

    logic       w_pcwrite, w_irwrite, w_iord, w_memreq, w_memwrite;
    logic       w_regwrite, w_regdst, w_memtoreg, w_alusrca, w_branch;
    logic [1:0] w_pcsrc, w_alusrcb;
    logic [3:0] w_aluop;
    logic       w_hilotoreg, w_hiorlo, w_hiwrite, w_lowrite, w_mdu_busy;

    // Output decode of the registered state (fetch strobes also wait on ready).
    always_comb begin
        w_pcwrite   = 1'b0;
        w_irwrite   = 1'b0;
        w_iord      = 1'b0;
        w_memreq    = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_regdst    = 1'b0;
        w_memtoreg  = 1'b0;
        w_alusrca   = 1'b0;
        w_branch    = 1'b0;
        w_pcsrc     = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = ALU_ADD;
        w_hilotoreg = 1'b0;
        w_hiorlo    = 1'b0;
        w_hiwrite   = 1'b0;
        w_lowrite   = 1'b0;
        w_mdu_busy  = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_memreq  = 1'b1;
                w_alusrcb = 2'b01;
                w_pcwrite = bus.mem_ready;
                w_irwrite = bus.mem_ready;
            end
            S_DECODE: w_alusrcb = 2'b11;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_memreq = 1'b1;
                w_iord   = 1'b1;
            end
            S_MEMWR: begin
                w_memreq   = 1'b1;
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_RTEXE: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_RTYPE;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_IMMEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                case (op_q)
                    OP_SLTI:  w_aluop = ALU_SLT;
                    OP_SLTIU: w_aluop = ALU_SLTU;
                    OP_ANDI:  w_aluop = ALU_AND;
                    OP_ORI:   w_aluop = ALU_OR;
                    OP_XORI:  w_aluop = ALU_XOR;
                    OP_LUI:   w_aluop = ALU_LUI;
                    default:  w_aluop = ALU_ADD;
                endcase
            end
            S_IMMWB: w_regwrite = 1'b1;
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_SUB;
                w_branch  = 1'b1;
                w_pcsrc   = 2'b01;
            end
            S_JUMP: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b10;
            end
            S_HILOWB: begin
                case (funct_q)
                    FN_MFHI: begin
                        w_regwrite  = 1'b1;
                        w_regdst    = 1'b1;
                        w_hilotoreg = 1'b1;
                    end
                    FN_MFLO: begin
                        w_regwrite  = 1'b1;
                        w_regdst    = 1'b1;
                        w_hilotoreg = 1'b1;
                        w_hiorlo    = 1'b1;
                    end
                    FN_MTHI: w_hiwrite = 1'b1;
                    FN_MTLO: w_lowrite = 1'b1;
                    default: ;
                endcase
            end
`ifdef MULTICYCLE_CTRL_MDU_EN
            S_MDU: begin
                w_mdu_busy = 1'b1;
                if (mdu_cnt_q == 6'd0) begin
                    w_hiwrite = 1'b1;
                    w_lowrite = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Every strobe and select is forced low while reset is held.
    assign bus.pcwrite     = resetn & w_pcwrite;
    assign bus.irwrite     = resetn & w_irwrite;
    assign bus.iord        = resetn & w_iord;
    assign bus.memreq      = resetn & w_memreq;
    assign bus.memwrite    = resetn & w_memwrite;
    assign bus.regwrite    = resetn & w_regwrite;
    assign bus.regdst      = resetn & w_regdst;
    assign bus.memtoreg    = resetn & w_memtoreg;
    assign bus.alusrca     = resetn & w_alusrca;
    assign bus.branch      = resetn & w_branch;
    assign bus.pcsrc       = {2{resetn}} & w_pcsrc;
    assign bus.alusrcb     = {2{resetn}} & w_alusrcb;
    assign bus.aluop       = {4{resetn}} & w_aluop;
    assign bus.hilotoreg   = resetn & w_hilotoreg;
    assign bus.hiorlo      = resetn & w_hiorlo;
    assign bus.hiwrite     = resetn & w_hiwrite;
    assign bus.lowrite     = resetn & w_lowrite;
    assign bus.mdu_busy    = resetn & w_mdu_busy;
    assign bus.bus_timeout = bus_timeout_q;
    assign bus.state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Scoreboard testbench for multicycle_ctrl (MDU_CYCLES=4,
//                MEM_WAIT_LIMIT=15); follows MULTICYCLE_CTRL_MDU_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                           S_RTEXE = 4'd6, S_ALUWB = 4'd7, S_BRANCH = 4'd8,
                           S_IMMEX = 4'd9, S_IMMWB = 4'd10, S_JUMP = 4'd11,
                           S_HILOWB = 4'd12, S_MDU = 4'd13;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6,
                           A_LUI = 4'd7, A_RTYPE = 4'd8;

    // Strobe vector bits: {branch, regwrite, hiwrite, lowrite, mdu_busy,
    //                      memwrite, pcwrite, irwrite, memreq}
    localparam logic [8:0] BR = 9'h100, RW = 9'h080, HW = 9'h040, LWR = 9'h020,
                           MB = 9'h010, MW = 9'h008, PW = 9'h004, IW = 9'h002,
                           MR = 9'h001, NONE = 9'h000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .MDU_CYCLES     (4),
        .MEM_WAIT_LIMIT (15)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic [3:0] st;
        logic [8:0] stb;
        logic       ca;
        logic [3:0] alu;
        logic       cs;
        logic [5:0] sel;
        logic       bt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] ins_op, ins_fn;
    logic       bt_exp;

    logic [8:0]  o_stb;
    logic [5:0]  o_sel;
    logic [27:0] o_all;
    assign o_stb = {bus.branch, bus.regwrite, bus.hiwrite, bus.lowrite, bus.mdu_busy,
                    bus.memwrite, bus.pcwrite, bus.irwrite, bus.memreq};
    assign o_sel = {bus.pcsrc, bus.regdst, bus.memtoreg, bus.hilotoreg, bus.hiorlo};
    assign o_all = {bus.state, bus.pcwrite, bus.irwrite, bus.iord, bus.memreq,
                    bus.memwrite, bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
                    bus.branch, bus.pcsrc, bus.alusrcb, bus.aluop, bus.hilotoreg,
                    bus.hiorlo, bus.hiwrite, bus.lowrite, bus.mdu_busy, bus.bus_timeout};

    function automatic void push(input logic [3:0] st, input logic rdy, input logic [8:0] stb,
                                 input logic ca, input logic [3:0] alu,
                                 input logic cs, input logic [5:0] sel);
        exp_t e;
        e.op = ins_op; e.fn = ins_fn; e.rdy = rdy; e.st = st; e.stb = stb;
        e.ca = ca; e.alu = alu; e.cs = cs; e.sel = sel; e.bt = bt_exp;
        sb.push_back(e);
    endfunction

    // FETCH completing immediately, then DECODE.
    function automatic void push_fd();
        push(S_FETCH, 1'b1, PW | IW | MR, 1'b1, A_ADD, 1'b1, 6'b000000);
        push(S_DECODE, 1'b0, NONE, 1'b1, A_ADD, 1'b0, 6'b0);
    endfunction

    function automatic void push_idle();
        push(S_FETCH, 1'b0, MR, 1'b1, A_ADD, 1'b0, 6'b0);
    endfunction

    function automatic string obs_str();
        return $sformatf("st=%0d stb=%b alu=%0d sel=%b bt=%b",
                         bus.state, o_stb, bus.aluop, o_sel, bus.bus_timeout);
    endfunction

    function automatic string exp_str(input exp_t e);
        return $sformatf("st=%0d stb=%b alu=%0d sel=%b bt=%b", e.st, e.stb, e.alu, e.sel, e.bt);
    endfunction

    // One clock: apply stimulus on the falling edge, sample just after.
    task automatic step(input exp_t e);
        @(negedge clk);
        bus.op        = e.op;
        bus.funct     = e.fn;
        bus.mem_ready = e.rdy;
        #1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.op        = 6'h23;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b1;
        bt_exp        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (o_all !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", o_all);
        end
        @(negedge clk);
        resetn        = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.memreq !== 1'b1 || bus.state !== S_FETCH) begin
            errors++;
            $display("FAIL reset_first_fetch: got memreq=%b st=%0d required memreq=1 st=0",
                     bus.memreq, bus.state);
        end
    endtask

    task automatic test_load();
        exp_t e;
        int   n = 0;
        ins_op = 6'h23; ins_fn = 6'h00;              // LW, ready late by 3 cycles
        push(S_FETCH, 1'b1, PW | IW | MR, 1'b1, A_ADD, 1'b0, 6'b0);
        push(S_DECODE, 1'b1, NONE, 1'b1, A_ADD, 1'b0, 6'b0);   // stray ready ignored
        push(S_MEMADR, 1'b1, NONE, 1'b1, A_ADD, 1'b0, 6'b0);
        repeat (3) push(S_MEMRD, 1'b0, MR, 1'b0, A_ADD, 1'b0, 6'b0);
        push(S_MEMRD, 1'b1, MR, 1'b0, A_ADD, 1'b0, 6'b0);
        push(S_MEMWB, 1'b0, RW, 1'b0, A_ADD, 1'b1, 6'b000100);
        ins_op = 6'h24;                               // LBU, ready at once
        push_fd();
        push(S_MEMADR, 1'b0, NONE, 1'b1, A_ADD, 1'b0, 6'b0);
        push(S_MEMRD, 1'b1, MR, 1'b0, A_ADD, 1'b0, 6'b0);
        push(S_MEMWB, 1'b0, RW, 1'b0, A_ADD, 1'b1, 6'b000100);
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL load #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_alu();
        exp_t       e;
        int         n = 0;
        logic [5:0] imm_op [8];
        logic [3:0] imm_alu [8];
        imm_op  = '{6'h0D, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0E, 6'h0F};
        imm_alu = '{A_OR, A_ADD, A_ADD, A_SLT, A_SLTU, A_AND, A_XOR, A_LUI};
        ins_op = 6'h00; ins_fn = 6'h21;               // ADDU
        push_fd();
        push(S_RTEXE, 1'b1, NONE, 1'b1, A_RTYPE, 1'b0, 6'b0);
        push(S_ALUWB, 1'b0, RW, 1'b0, A_ADD, 1'b1, 6'b001000);
        for (int i = 0; i < 8; i++) begin
            ins_op = imm_op[i]; ins_fn = 6'h00;
            push_fd();
            push(S_IMMEX, 1'b0, NONE, 1'b1, imm_alu[i], 1'b0, 6'b0);
            push(S_IMMWB, 1'b0, RW, 1'b0, A_ADD, 1'b1, 6'b000000);
        end
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL alu #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_mdu();
        exp_t       e;
        int         n = 0;
        logic [5:0] fns [2];
        fns = '{6'h18, 6'h1B};                        // MULT, DIVU
        for (int i = 0; i < 2; i++) begin
            ins_op = 6'h00; ins_fn = fns[i];
            push_fd();
`ifdef MULTICYCLE_CTRL_MDU_EN
            repeat (3) push(S_MDU, 1'b1, MB, 1'b0, A_ADD, 1'b0, 6'b0);
            push(S_MDU, 1'b0, MB | HW | LWR, 1'b0, A_ADD, 1'b0, 6'b0);
`endif
        end
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL mdu #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_hilo();
        exp_t       e;
        int         n = 0;
        logic [5:0] fns [4];
        logic [8:0] stbs [4];
        logic [5:0] sels [4];
        fns  = '{6'h10, 6'h12, 6'h11, 6'h13};         // MFHI, MFLO, MTHI, MTLO
        stbs = '{RW, RW, HW, LWR};
        sels = '{6'b001010, 6'b001011, 6'b000000, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            ins_op = 6'h00; ins_fn = fns[i];
            push_fd();
            push(S_HILOWB, 1'b0, stbs[i], 1'b0, A_ADD, (i < 2), sels[i]);
        end
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL hilo #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_branch_jump();
        exp_t       e;
        int         n = 0;
        logic [5:0] bops [5];
        logic [5:0] other [2];
        bops  = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
        other = '{6'h3F, 6'h10};                      // unknown opcodes
        for (int i = 0; i < 5; i++) begin
            ins_op = bops[i]; ins_fn = 6'h00;
            push_fd();
            push(S_BRANCH, 1'b0, BR, 1'b1, A_SUB, 1'b1, 6'b010000);
        end
        for (int i = 0; i < 2; i++) begin
            ins_op = 6'h02 + 6'(i); ins_fn = 6'h00;   // J, JAL
            push_fd();
            push(S_JUMP, 1'b0, PW, 1'b0, A_ADD, 1'b1, 6'b100000);
        end
        for (int i = 0; i < 2; i++) begin
            ins_op = other[i]; ins_fn = 6'h00;
            push_fd();
        end
        ins_op = 6'h00; ins_fn = 6'h1A;               // DIV: FETCH return without the MDU
        push_fd();
`ifdef MULTICYCLE_CTRL_MDU_EN
        repeat (3) push(S_MDU, 1'b0, MB, 1'b0, A_ADD, 1'b0, 6'b0);
        push(S_MDU, 1'b0, MB | HW | LWR, 1'b0, A_ADD, 1'b0, 6'b0);
`endif
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL branch_jump #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_mem_limit();
        exp_t e;
        int   n = 0;
        ins_op = 6'h2B; ins_fn = 6'h00;               // SW, ready on the limit cycle
        push_fd();
        push(S_MEMADR, 1'b0, NONE, 1'b1, A_ADD, 1'b0, 6'b0);
        repeat (14) push(S_MEMWR, 1'b0, MW | MR, 1'b0, A_ADD, 1'b0, 6'b0);
        push(S_MEMWR, 1'b1, MW | MR, 1'b0, A_ADD, 1'b0, 6'b0);
        ins_op = 6'h29;                               // SH, ready never comes
        push_fd();
        push(S_MEMADR, 1'b0, NONE, 1'b1, A_ADD, 1'b0, 6'b0);
        repeat (15) push(S_MEMWR, 1'b0, MW | MR, 1'b0, A_ADD, 1'b0, 6'b0);
        bt_exp = 1'b1;
        push_idle();
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL mem_limit #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n = 0;
`ifdef MULTICYCLE_CTRL_MDU_EN
        ins_op = 6'h00; ins_fn = 6'h18;               // MULT, reset with counter at 2
        push_fd();
        repeat (2) push(S_MDU, 1'b0, MB, 1'b0, A_ADD, 1'b0, 6'b0);
`else
        ins_op = 6'h23; ins_fn = 6'h00;               // LW, reset while waiting
        push_fd();
        push(S_MEMADR, 1'b0, NONE, 1'b1, A_ADD, 1'b0, 6'b0);
        repeat (2) push(S_MEMRD, 1'b0, MR, 1'b0, A_ADD, 1'b0, 6'b0);
`endif
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL reset_mid #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
        resetn        = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (o_all !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid_abort: got %h required 0", o_all);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_all !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid_hold: got %h required 0", o_all);
        end
        @(negedge clk);
        resetn        = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.memreq !== 1'b1 || bus.state !== S_FETCH || bus.bus_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got memreq=%b st=%0d bt=%b required memreq=1 st=0 bt=0",
                     bus.memreq, bus.state, bus.bus_timeout);
        end
        bt_exp = 1'b0;
        ins_op = 6'h00; ins_fn = 6'h21;               // ADDU after recovery
        push_fd();
        push(S_RTEXE, 1'b0, NONE, 1'b1, A_RTYPE, 1'b0, 6'b0);
        push(S_ALUWB, 1'b0, RW, 1'b0, A_ADD, 1'b1, 6'b001000);
        push_idle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e);
            checks++; n++;
            if (bus.state !== e.st || o_stb !== e.stb || bus.bus_timeout !== e.bt ||
                (e.ca && bus.aluop !== e.alu) || (e.cs && o_sel !== e.sel)) begin
                errors++;
                $display("FAIL recover #%0d: got %s required %s", n, obs_str(), exp_str(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_mdu();
        test_hilo();
        test_branch_jump();
        test_mem_limit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
